run_controller: RTL and testbench

RUN_CONTROLLER -- requirements
Module: run_controller

---
 rtl/run_controller.sv | 138 +++++++++++++
 tb/tb_run_controller.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/run_controller.sv
// Run sequencer for a self-checking testbench: clear, run, drain, freeze, report.
// Optional stall watchdog is compiled in with `define RUN_TIMEOUT_EN.
module run_controller #(
  parameter int WIDTH        = 32,
  parameter int CLR_CYCLES   = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int TIMEOUT      = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_run_len,
  input  logic [WIDTH-1:0] i_data_ctr,
  input  logic [WIDTH-1:0] i_event_ctr,
  output logic             o_tb_reset,
  output logic             o_tb_enable,
  output logic             o_tb_freeze,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic             o_aborted,
  output logic             o_timeout,
  output logic [WIDTH-1:0] o_res_data,
  output logic [WIDTH-1:0] o_res_events
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_FREEZE, S_DONE
  } state_t;

  localparam logic [3:0] CLR_LAST   = 4'(CLR_CYCLES - 1);
  // A zero-length drain still spends its single pass-through cycle in DRAIN.
  localparam logic [3:0] DRAIN_LAST = (DRAIN_CYCLES == 0) ? 4'd0 : 4'(DRAIN_CYCLES - 1);

  state_t           state, state_next;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] run_len;
  logic             busy_now, start_ok, abort_ok, capture, wd_fire;

  assign busy_now = (state == S_CLEAR) || (state == S_RUN) ||
                    (state == S_DRAIN) || (state == S_FREEZE);
  assign abort_ok = i_abort && busy_now;
  assign start_ok = i_start && !i_abort && ((state == S_IDLE) || (state == S_DONE));

`ifdef RUN_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0]  wd_cnt;
  logic [WIDTH-1:0] data_prev;
  logic             stalled;

  assign stalled = (state == S_RUN) && (i_data_ctr == data_prev);
  assign wd_fire = stalled && (wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt    <= '0;
      data_prev <= '0;
      o_timeout <= 1'b0;
    end else begin
      data_prev <= i_data_ctr;
      if (!stalled)
        wd_cnt <= '0;
      else if (wd_cnt != WD_MAX)
        wd_cnt <= wd_cnt + 1'b1;
      if (start_ok)
        o_timeout <= 1'b0;
      else if (wd_fire && !abort_ok)
        o_timeout <= 1'b1;
    end
  end
`else
  assign wd_fire   = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // NOTE: next state is assigned a default first so no path through the
  // case leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    if (abort_ok) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start_ok) state_next = S_CLEAR;
        S_CLEAR:  if (cnt == CLR_LAST) state_next = (run_len == '0) ? S_DRAIN : S_RUN;
        S_RUN:    if ((i_data_ctr >= run_len) || wd_fire) state_next = S_DRAIN;
        S_DRAIN:  if (cnt == DRAIN_LAST) state_next = S_FREEZE;
        S_FREEZE: state_next = S_DONE;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  assign capture = (state == S_FREEZE) && (state_next == S_DONE);

  // Outputs are decoded from the next state so they are registered yet
  // line up with the cycle the FSM spends in that state.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      run_len      <= '0;
      o_tb_reset   <= 1'b1;
      o_tb_enable  <= 1'b0;
      o_tb_freeze  <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_pass       <= 1'b0;
      o_aborted    <= 1'b0;
      o_res_data   <= '0;
      o_res_events <= '0;
    end else begin
      state       <= state_next;
      cnt         <= (state_next != state) ? 4'd0 : cnt + 4'd1;
      o_tb_reset  <= (state_next == S_CLEAR);
      o_tb_enable <= (state_next == S_RUN);
      o_tb_freeze <= (state_next == S_FREEZE) || (state_next == S_DONE);
      o_busy      <= (state_next == S_CLEAR) || (state_next == S_RUN) ||
                     (state_next == S_DRAIN) || (state_next == S_FREEZE);
      o_done      <= (state_next == S_DONE);
      o_pass      <= (state_next == S_DONE) && (capture ? (i_event_ctr == '0) : o_pass);
      o_aborted   <= abort_ok;
      if (start_ok)
        run_len <= i_run_len;
      if (capture) begin
        o_res_data   <= i_data_ctr;
        o_res_events <= i_event_ctr;
      end
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller; a mock scoreboard counts one sample per
// enabled cycle. Define RUN_TIMEOUT_EN to also exercise the stall watchdog.
module tb_run_controller;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, i_start, i_abort, stuck;
  logic [W-1:0] i_run_len, i_event_ctr, data_ctr, sample_cnt;
  logic         tb_reset, tb_enable, tb_freeze, busy, done, pass, aborted, timeout;
  logic [W-1:0] res_data, res_events;

  int n_tests = 0;
  int n_fail  = 0;
  int m_rst, m_en, m_drain, m_frz, m_ovl;

  always #5 clk = ~clk;

  run_controller #(.WIDTH(W), .CLR_CYCLES(4), .DRAIN_CYCLES(3), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_abort(i_abort),
    .i_run_len(i_run_len), .i_data_ctr(data_ctr), .i_event_ctr(i_event_ctr),
    .o_tb_reset(tb_reset), .o_tb_enable(tb_enable), .o_tb_freeze(tb_freeze),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_aborted(aborted),
    .o_timeout(timeout), .o_res_data(res_data), .o_res_events(res_events)
  );

  // Mock scoreboard: the sample produced in an enabled cycle is visible that cycle.
  always @(posedge clk)
    if (tb_reset) sample_cnt <= '0;
    else if (tb_enable) sample_cnt <= sample_cnt + 1;

  always_comb data_ctr = stuck ? W'(5) : sample_cnt + W'(tb_enable);

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [W-1:0] len);
    @(negedge clk);
    i_start   = 1'b1;
    i_run_len = len;
  endtask

  // Observe one run cycle by cycle until o_done, tallying phase lengths.
  task automatic measure();
    bit seen = 1'b0;
    m_rst = 0; m_en = 0; m_drain = 0; m_frz = 0; m_ovl = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      i_start = 1'b0;
      i_abort = 1'b0;
      if (tb_reset) m_rst++;
      if (tb_enable) m_en++;
      if (tb_reset && tb_enable) m_ovl++;
      if (busy && !tb_reset && !tb_enable && !tb_freeze) m_drain++;
      if (busy && tb_freeze) m_frz++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_wait", 0, 1);
  endtask

  task automatic wait_enable(input int n);
    int k = 0;
    for (int c = 0; c < 100 && k < n; c++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (tb_enable) k++;
    end
    if (k < n) check("enable_wait", W'(k), W'(n));
  endtask

  initial begin
    reset = 1'b1; i_start = 1'b0; i_abort = 1'b0; stuck = 1'b0;
    i_run_len = '0; i_event_ctr = '0;

    repeat (3) @(negedge clk);
    check("rst_tb_reset", W'(tb_reset), 1);
    check("rst_busy", W'(busy), 0);
    check("rst_enable", W'(tb_enable), 0);
    check("rst_done", W'(done), 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_events", res_events, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_tb_reset", W'(tb_reset), 0);

    // Normal run, no events
    pulse_start(10);
    measure();
    check("r10_clear", W'(m_rst), 4);
    check("r10_enable", W'(m_en), 10);
    check("r10_drain", W'(m_drain), 3);
    check("r10_freeze", W'(m_frz), 1);
    check("r10_overlap", W'(m_ovl), 0);
    check("r10_pass", W'(pass), 1);
    check("r10_res_data", res_data, 10);
    check("r10_res_events", res_events, 0);
    check("r10_timeout", W'(timeout), 0);
    @(negedge clk);
    check("done_hold", W'(done), 1);
    check("done_freeze", W'(tb_freeze), 1);

    // Abort while DONE is ignored
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    check("abort_done_ack", W'(aborted), 0);
    check("abort_done_hold", W'(done), 1);

    // Run with events
    i_event_ctr = 3;
    pulse_start(10);
    measure();
    check("ev_res_events", res_events, 3);
    check("ev_pass", W'(pass), 0);
    check("ev_res_data", res_data, 10);

    // Zero-length run
    pulse_start(0);
    measure();
    check("z_enable", W'(m_en), 0);
    check("z_clear", W'(m_rst), 4);
    check("z_drain", W'(m_drain), 3);
    check("z_freeze", W'(m_frz), 1);
    check("z_res_data", res_data, 0);

    // Abort in 5th RUN cycle, then a short run
    pulse_start(10);
    wait_enable(5);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    check("ab_ack", W'(aborted), 1);
    check("ab_busy", W'(busy), 0);
    check("ab_enable", W'(tb_enable), 0);
    check("ab_freeze", W'(tb_freeze), 0);
    check("ab_done", W'(done), 0);
    check("ab_res_data", res_data, 0);
    @(negedge clk);
    check("ab_ack_once", W'(aborted), 0);
    pulse_start(2);
    measure();
    check("ab2_enable", W'(m_en), 2);
    check("ab2_res_data", res_data, 2);

    // Start and abort together while busy
    pulse_start(10);
    wait_enable(1);
    i_start = 1'b1; i_abort = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_abort = 1'b0;
    check("sa_busy_ack", W'(aborted), 1);
    check("sa_busy_state", W'(busy), 0);

    // Start and abort together in IDLE: nothing happens
    @(negedge clk);
    i_start = 1'b1; i_abort = 1'b1; i_run_len = 5;
    @(negedge clk);
    i_start = 1'b0; i_abort = 1'b0;
    check("sa_idle_busy", W'(busy), 0);
    check("sa_idle_ack", W'(aborted), 0);
    check("sa_idle_clear", W'(tb_reset), 0);

    // Start during RUN is ignored; run length stays 3
    pulse_start(3);
    wait_enable(1);
    i_start = 1'b1; i_run_len = 20;
    measure();
    check("sr_enable", W'(m_en + 1), 3);
    check("sr_res_data", res_data, 3);

    // Reset mid-run
    pulse_start(10);
    wait_enable(3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mr_tb_reset", W'(tb_reset), 1);
    check("mr_busy", W'(busy), 0);
    check("mr_enable", W'(tb_enable), 0);
    check("mr_ack", W'(aborted), 0);
    check("mr_res_data", res_data, 0);
    check("mr_res_events", res_events, 0);
    @(negedge clk);
    check("mr_release", W'(tb_reset), 0);

`ifdef RUN_TIMEOUT_EN
    // Stalled scoreboard trips the watchdog
    stuck = 1'b1;
    i_event_ctr = 0;
    pulse_start(100);
    measure();
    check("wd_timeout", W'(timeout), 1);
    check("wd_enable", W'(m_en), 8);
    check("wd_done", W'(done), 1);
    check("wd_res_data", res_data, 5);
    stuck = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
